// File: rtl/chaser_pkg.sv
// Shared types and defaults for the chaser/PWM fader: mode and direction encodings,
// the figure-8 segment walk, and the full-brightness level helper.
package chaser_pkg;

  typedef enum logic [1:0] {
    MODE_FWD    = 2'b00,
    MODE_REV    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Figure-8 on a 7-seg display (a=0 .. g=6): a,b,g,e,d,c,g,f; entry 0 sits in the LSBs.
  localparam logic [23:0] DEFAULT_SEQ_MAP = {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

  function automatic int unsigned level_max(input int unsigned fade_w);
    return (32'd1 << fade_w) - 32'd1;
  endfunction

endpackage

// File: rtl/chaser_pwm_fader_if.sv
// Control/status bundle of the chaser: master drives the configuration and
// observes the PWM outputs, slave is the chaser itself.
interface chaser_pwm_fader_if
  import chaser_pkg::*;
#(
  parameter int N_CH    = 7,
  parameter int SEQ_LEN = 8,
  parameter int STEP_W  = 23,
  parameter int FDIV_W  = 22
) ();

  localparam int POS_W = $clog2(SEQ_LEN);

  logic              en;
  logic [STEP_W-1:0] period;
  logic [FDIV_W-1:0] fade_div;
  mode_e             mode;
  logic              tail_en;
  logic              decay_lin;
  logic              invert;
  logic [N_CH-1:0]   led_out;
  logic [POS_W-1:0]  pos;
  logic              step_pulse;

  modport master (
    output en, period, fade_div, mode, tail_en, decay_lin, invert,
    input  led_out, pos, step_pulse
  );

  modport slave (
    input  en, period, fade_div, mode, tail_en, decay_lin, invert,
    output led_out, pos, step_pulse
  );

endinterface

// File: rtl/chaser_pwm_fader_channel.sv
// One output channel: brightness level register with max/clear/decay control
// and a registered PWM comparator against the shared free-running counter.
module pwm_fade_channel
  import chaser_pkg::*;
#(
  parameter int FADE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_max,
  input  logic              clear,
  input  logic              fade_tick,
  input  logic              decay_lin,
  input  logic [FADE_W-1:0] pwm_cnt,
  input  logic              invert,
  output logic              led
);

  localparam logic [FADE_W-1:0] LEVEL_MAX = FADE_W'(level_max(FADE_W));

  logic [FADE_W-1:0] level;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      // NOTE: led resets to 0 without invert so a held reset always blanks the pins the same way.
      led   <= 1'b0;
    end else begin
      if (set_max) begin
        level <= LEVEL_MAX;
      end else if (clear) begin
        level <= '0;
      end else if (fade_tick) begin
        if (decay_lin) begin
          level <= (level == '0) ? '0 : level - FADE_W'(1);
        end else begin
          level <= level >> 1;
        end
      end
      led <= (level > pwm_cnt) ^ invert;
    end
  end

endmodule

// File: rtl/chaser_pwm_fader.sv
// Chaser top: step/fade prescalers, pointer FSM walking SEQ_MAP, and one
// fading PWM channel per output.
module chaser_pwm_fader
  import chaser_pkg::*;
#(
  parameter int                       N_CH    = 7,
  parameter int                       IDX_W   = $clog2(N_CH),
  parameter int                       SEQ_LEN = 8,
  parameter logic [SEQ_LEN*IDX_W-1:0] SEQ_MAP = DEFAULT_SEQ_MAP,
  parameter int                       FADE_W  = 4,
  parameter int                       STEP_W  = 23,
  parameter int                       FDIV_W  = 22
) (
  input logic               clk,
  input logic               reset,
  chaser_pwm_fader_if.slave bus
);

  localparam int               POS_W    = $clog2(SEQ_LEN);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SEQ_LEN - 1);

  logic [STEP_W-1:0] step_cnt;
  logic [FDIV_W-1:0] fade_cnt;
  logic [FADE_W-1:0] pwm_cnt;
  logic [POS_W-1:0]  pos;
  dir_e              dir;
  logic              step_pulse;
  logic [N_CH-1:0]   led;
  logic              step_tick;
  logic              fade_tick;
  logic [IDX_W-1:0]  active_idx;

  // >= rather than == so shrinking period below the running count ticks at once.
  assign step_tick  = bus.en && (step_cnt >= bus.period);
  assign fade_tick  = (fade_cnt >= bus.fade_div);
  assign active_idx = SEQ_MAP[int'(pos)*IDX_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      fade_cnt <= '0;
      pwm_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (bus.en) begin
        step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
      end
      fade_cnt <= fade_tick ? '0 : fade_cnt + FDIV_W'(1);
      pwm_cnt  <= pwm_cnt + FADE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos        <= '0;
      dir        <= DIR_UP;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step_tick;
      if (step_tick) begin
        unique case (bus.mode)
          MODE_FWD:    pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
          MODE_REV:    pos <= (pos == '0) ? POS_LAST : pos - POS_W'(1);
          MODE_BOUNCE: begin
            // Reflect at the ends without dwelling on them.
            if (dir == DIR_UP) begin
              if (pos == POS_LAST) begin
                dir <= DIR_DOWN;
                pos <= pos - POS_W'(1);
              end else begin
                pos <= pos + POS_W'(1);
              end
            end else begin
              if (pos == '0) begin
                dir <= DIR_UP;
                pos <= pos + POS_W'(1);
              end else begin
                pos <= pos - POS_W'(1);
              end
            end
          end
          MODE_HOLD:   pos <= pos;
        endcase
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwm_fade_channel #(
      .FADE_W (FADE_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .set_max   (active_idx == IDX_W'(c)),
      .clear     (!bus.tail_en),
      .fade_tick (fade_tick),
      .decay_lin (bus.decay_lin),
      .pwm_cnt   (pwm_cnt),
      .invert    (bus.invert),
      .led       (led[c])
    );
  end

  assign bus.led_out    = led;
  assign bus.pos        = pos;
  assign bus.step_pulse = step_pulse;

endmodule

// File: tb/tb_chaser_pwm_fader.sv
// Scoreboard bench: a behavioural model predicts pos/step_pulse/led_out after every
// edge, a negedge monitor pops and compares against the DUT.
module tb_chaser_pwm_fader;
  import chaser_pkg::*;

  localparam int N_CH    = 7;
  localparam int SEQ_LEN = 8;
  localparam int LVL_MAX = 15;
  localparam int PWM_MOD = 16;

  typedef struct packed {
    logic [2:0]      pos;
    logic            pulse;
    logic [N_CH-1:0] led;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  chaser_pwm_fader_if bus ();

  chaser_pwm_fader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  exp_t exp_q[$];

  // Figure-8 segment order a,b,g,e,d,c,g,f.
  int seq_map[SEQ_LEN] = '{0, 1, 6, 4, 3, 2, 6, 5};

  int        m_step, m_fade, m_pwm, m_pos, m_dir;
  int        m_lvl[N_CH];
  bit [N_CH-1:0] m_led;
  bit        m_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cycle, act, expv);
    end
  endtask

  // Reference model: evaluated once per rising edge on pre-edge state and inputs.
  always @(posedge clk) begin
    exp_t e;
    bit   tick, ftick;
    int   nxt;
    cycle++;
    if (reset) begin
      m_step = 0; m_fade = 0; m_pwm = 0; m_pos = 0; m_dir = 1;
      m_led = '0; m_pulse = 0;
      for (int c = 0; c < N_CH; c++) m_lvl[c] = 0;
    end else begin
      tick  = bus.en && (m_step >= int'(bus.period));
      ftick = (m_fade >= int'(bus.fade_div));
      for (int c = 0; c < N_CH; c++) m_led[c] = (m_lvl[c] > m_pwm) ^ bus.invert;
      for (int c = 0; c < N_CH; c++) begin
        if (c == seq_map[m_pos])   m_lvl[c] = LVL_MAX;
        else if (!bus.tail_en)     m_lvl[c] = 0;
        else if (ftick)            m_lvl[c] = bus.decay_lin ? ((m_lvl[c] > 0) ? m_lvl[c] - 1 : 0)
                                                            : m_lvl[c] / 2;
      end
      if (bus.en) m_step = tick ? 0 : m_step + 1;
      m_fade  = ftick ? 0 : m_fade + 1;
      m_pwm   = (m_pwm + 1) % PWM_MOD;
      m_pulse = tick;
      if (tick) begin
        case (bus.mode)
          MODE_FWD: m_pos = (m_pos + 1) % SEQ_LEN;
          MODE_REV: m_pos = (m_pos + SEQ_LEN - 1) % SEQ_LEN;
          MODE_BOUNCE: begin
            nxt = m_pos + m_dir;
            if (nxt < 0 || nxt >= SEQ_LEN) begin
              m_dir = -m_dir;
              nxt   = m_pos + m_dir;
            end
            m_pos = nxt;
          end
          default: ;
        endcase
      end
    end
    e.pos   = 3'(m_pos);
    e.pulse = m_pulse;
    e.led   = m_led;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pos",        32'(bus.pos),        32'(e.pos));
      check("step_pulse", 32'(bus.step_pulse), 32'(e.pulse));
      check("led_out",    32'(bus.led_out),    32'(e.led));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input bit en, input int period, input int fdiv, input mode_e mode,
                       input bit tail, input bit lin, input bit inv);
    bus.en        = en;
    bus.period    = 23'(period);
    bus.fade_div  = 22'(fdiv);
    bus.mode      = mode;
    bus.tail_en   = tail;
    bus.decay_lin = lin;
    bus.invert    = inv;
  endtask

  initial begin
    reset = 1'b1;
    setup(1'b1, 3, 0, MODE_FWD, 1'b0, 1'b0, 1'b0);
    cycles(3);
    reset = 1'b0;

    // Forward walk, no tail.
    cycles(40);
    // Bounce at full speed, then reverse.
    setup(1'b1, 0, 0, MODE_BOUNCE, 1'b0, 1'b0, 1'b0);
    cycles(30);
    setup(1'b1, 0, 0, MODE_REV, 1'b0, 1'b0, 1'b0);
    cycles(20);
    // Exponential then linear tails.
    setup(1'b1, 5, 0, MODE_FWD, 1'b1, 1'b0, 1'b0);
    cycles(48);
    setup(1'b1, 20, 0, MODE_FWD, 1'b1, 1'b1, 1'b0);
    cycles(60);
    // Inverted outputs with a hold mode.
    setup(1'b1, 4, 1, MODE_HOLD, 1'b1, 1'b0, 1'b1);
    cycles(40);
    // Freeze mid-count, then drop period below the count.
    setup(1'b1, 20, 2, MODE_FWD, 1'b1, 1'b1, 1'b0);
    cycles(12);
    bus.en = 1'b0;
    cycles(10);
    bus.en = 1'b1;
    bus.period = 23'd2;
    cycles(10);
    // Reset mid-fade with invert.
    setup(1'b1, 1, 3, MODE_BOUNCE, 1'b1, 1'b1, 1'b1);
    cycles(15);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(20);

    // Randomised segments.
    for (int s = 0; s < 150; s++) begin
      setup($urandom_range(0, 3) != 0, $urandom_range(0, 6), $urandom_range(0, 3),
            mode_e'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      reset = ($urandom_range(0, 19) == 0);
      cycles(1);
      reset = 1'b0;
      cycles($urandom_range(4, 24));
    end

    cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
